// File: rtl/alu_share_arbiter_if.sv
// Bundle between the ALU arbiter and its environment: two request ports,
// the shared ALU's operand/result lines and the tagged response channel.
interface alu_share_arbiter_if;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_a0;
    logic [3:0] req_b0;
    logic [2:0] req_s0;
    logic [3:0] req_a1;
    logic [3:0] req_b1;
    logic [2:0] req_s1;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_s;
    logic [4:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_out;
    logic       rsp_err;
    logic       rsp_id;
    logic [7:0] op_count;

    modport master (
        output req_valid, req_a0, req_b0, req_s0, req_a1, req_b1, req_s1,
        output alu_out, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_s,
        input  rsp_valid, rsp_out, rsp_err, rsp_id, op_count
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_s0, req_a1, req_b1, req_s1,
        input  alu_out, rsp_ready,
        output req_ready, alu_a, alu_b, alu_s,
        output rsp_valid, rsp_out, rsp_err, rsp_id, op_count
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational 4-bit ALU between two requesters, with
// round-robin or fixed-priority grant, div/mod-by-zero trapping and a tagged response.
module alu_share_arbiter #(
    parameter bit PRIORITY_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   grant_any;
    logic   grant_id;

    function automatic logic is_trap(input logic [2:0] s, input logic [3:0] b);
        return ((s == 3'b011) || (s == 3'b100)) && (b == 4'd0);
    endfunction

    function automatic logic [4:0] trap_result(input logic [2:0] s, input logic [3:0] b,
                                               input logic [4:0] r);
        return is_trap(s, b) ? 5'd0 : r;
    endfunction

    // Tie goes to whoever was not served last unless fixed priority is selected.
    always_comb begin
        grant_any = (state == IDLE) && !reset && (bus.req_valid != 2'b00);
        case (bus.req_valid)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = PRIORITY_MODE ? 1'b0 : ~last_grant;
            default: grant_id = 1'b0;
        endcase
        bus.req_ready = 2'b00;
        if (grant_any) begin
            bus.req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.alu_a     <= 4'd0;
            bus.alu_b     <= 4'd0;
            bus.alu_s     <= 3'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_out   <= 5'd0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.op_count  <= 8'd0;
            last_grant    <= 1'b1;
        end else begin
            if (grant_any) begin
                bus.alu_a  <= grant_id ? bus.req_a1 : bus.req_a0;
                bus.alu_b  <= grant_id ? bus.req_b1 : bus.req_b0;
                bus.alu_s  <= grant_id ? bus.req_s1 : bus.req_s0;
                bus.rsp_id <= grant_id;
                last_grant <= grant_id;
            end
            // ALU operands have been stable for a full cycle by the end of EXEC.
            if (state == EXEC) begin
                bus.rsp_out   <= trap_result(bus.alu_s, bus.alu_b, bus.alu_out);
                bus.rsp_err   <= is_trap(bus.alu_s, bus.alu_b);
                bus.rsp_valid <= 1'b1;
            end
            if ((state == RESP) && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
                bus.op_count  <= bus.op_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: randomized and directed requests,
// grant/latency checker on the request side, response monitor on the other.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_share_arbiter_if bus ();
    alu_share_arbiter_if bus_fp ();

    alu_share_arbiter #(.PRIORITY_MODE(1'b0)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    alu_share_arbiter #(.PRIORITY_MODE(1'b1)) dut_fp (.clk(clk), .reset(reset), .bus(bus_fp.slave));

    // Behavioural ALU attached to each arbiter; div/mod by zero returns junk.
    function automatic logic [4:0] alu_comb(input logic [3:0] a, input logic [3:0] b,
                                            input logic [2:0] s);
        case (s)
            3'd0:    return {1'b0, a};
            3'd1:    return {1'b0, a} + {1'b0, b};
            3'd2:    return {1'b0, a} - {1'b0, b};
            3'd3:    return (b == 4'd0) ? 5'h1f : {1'b0, a / b};
            3'd4:    return (b == 4'd0) ? 5'h1f : {1'b0, a % b};
            3'd5:    return {a, 1'b0};
            3'd6:    return {2'b00, a[3:1]};
            default: return {4'd0, (a > b)};
        endcase
    endfunction

    assign bus.alu_out    = alu_comb(bus.alu_a, bus.alu_b, bus.alu_s);
    assign bus_fp.alu_out = alu_comb(bus_fp.alu_a, bus_fp.alu_b, bus_fp.alu_s);

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void ref_model(input int a, input int b, input int s,
                                      output int out, output int err);
        err = 0;
        out = 0;
        if ((s == 3 || s == 4) && b == 0) begin
            err = 1;
        end else begin
            case (s)
                0: out = a;
                1: out = (a + b) % 32;
                2: out = (a - b + 32) % 32;
                3: out = a / b;
                4: out = a % b;
                5: out = a * 2;
                6: out = a / 2;
                default: out = (a > b) ? 1 : 0;
            endcase
        end
    endfunction

    typedef struct { int out; int err; int id; } exp_t;
    exp_t       q[$];
    int         grant_log[$];
    int         phase = 0;      // 0 free, 1 result pending, 2 response presented
    logic       ptr = 1'b1;     // requester served most recently
    int         acc_cnt[2] = '{0, 0};
    int         seen_cnt[2] = '{0, 0};
    int         last_a, last_b, last_s;
    int         w_m, o_m, e_m;
    exp_t       e_m_t;
    logic [7:0] exp_count = 8'd0;

    // Request-side checker: predicts grants and response timing, records expectations.
    always @(negedge clk) begin
        if (reset) begin
            chk("ready_in_reset", int'(bus.req_ready), 0);
            phase = 0;
            ptr = 1'b1;
        end else begin
            chk("rsp_valid_timing", int'(bus.rsp_valid), (phase == 2) ? 1 : 0);
            if (phase == 1) begin
                chk("alu_a", int'(bus.alu_a), last_a);
                chk("alu_b", int'(bus.alu_b), last_b);
                chk("alu_s", int'(bus.alu_s), last_s);
            end
            if (phase == 0 && bus.req_valid != 2'b00) begin
                if (bus.req_valid == 2'b11) w_m = ptr ? 0 : 1;
                else w_m = bus.req_valid[1] ? 1 : 0;
                chk("req_ready_grant", int'(bus.req_ready), 1 << w_m);
                last_a = (w_m == 1) ? int'(bus.req_a1) : int'(bus.req_a0);
                last_b = (w_m == 1) ? int'(bus.req_b1) : int'(bus.req_b0);
                last_s = (w_m == 1) ? int'(bus.req_s1) : int'(bus.req_s0);
                ref_model(last_a, last_b, last_s, o_m, e_m);
                e_m_t.out = o_m;
                e_m_t.err = e_m;
                e_m_t.id  = w_m;
                q.push_back(e_m_t);
                grant_log.push_back(w_m);
                acc_cnt[w_m]++;
                ptr = (w_m == 1);
                phase = 1;
            end else begin
                chk("req_ready_idle", int'(bus.req_ready), 0);
                if (phase == 1) phase = 2;
                else if (phase == 2 && bus.rsp_ready) phase = 0;
            end
        end
    end

    // Response monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            exp_count = 8'd0;
        end else begin
            chk("op_count", int'(bus.op_count), int'(exp_count));
            if (bus.rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    chk("rsp_out", int'(bus.rsp_out), q[0].out);
                    chk("rsp_err", int'(bus.rsp_err), q[0].err);
                    chk("rsp_id", int'(bus.rsp_id), q[0].id);
                    if (bus.rsp_ready) begin
                        void'(q.pop_front());
                        exp_count++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc_cnt[i] != seen_cnt[i]) begin
                seen_cnt[i] = acc_cnt[i];
                bus.req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic drive(input int i, input int a, input int b, input int s);
        if (i == 0) begin
            bus.req_a0 = a[3:0]; bus.req_b0 = b[3:0]; bus.req_s0 = s[2:0];
        end else begin
            bus.req_a1 = a[3:0]; bus.req_b1 = b[3:0]; bus.req_s1 = s[2:0];
        end
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((phase != 0 || bus.req_valid != 2'b00) && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) chk("timeout_idle", 0, 1);
    endtask

    task automatic issue(input int i, input int a, input int b, input int s);
        drive(i, a, b, s);
        wait_idle();
    endtask

    task automatic check_reset_values();
        @(negedge clk);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_out", int'(bus.rsp_out), 0);
        chk("rst_rsp_err", int'(bus.rsp_err), 0);
        chk("rst_rsp_id", int'(bus.rsp_id), 0);
        chk("rst_alu_a", int'(bus.alu_a), 0);
        chk("rst_alu_b", int'(bus.alu_b), 0);
        chk("rst_alu_s", int'(bus.alu_s), 0);
        chk("rst_op_count", int'(bus.op_count), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req_valid = 2'b00;
        repeat (2) step();
        reset = 1'b0;
        check_reset_values();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int cnt;
        int rsp_cnt;
        int exp_rr[4];
        exp_rr = '{0, 1, 0, 1};
        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_a0 = 4'd0; bus.req_b0 = 4'd0; bus.req_s0 = 3'd0;
        bus.req_a1 = 4'd0; bus.req_b1 = 4'd0; bus.req_s1 = 3'd0;
        bus.rsp_ready = 1'b0;
        bus_fp.req_valid = 2'b00;
        bus_fp.req_a0 = 4'd6; bus_fp.req_b0 = 4'd3; bus_fp.req_s0 = 3'd1;
        bus_fp.req_a1 = 4'd2; bus_fp.req_b1 = 4'd1; bus_fp.req_s1 = 3'd2;
        bus_fp.rsp_ready = 1'b1;
        do_reset();

        bus.rsp_ready = 1'b1;
        issue(0, 9, 4, 1);
        @(negedge clk);
        chk("single_add_count", int'(bus.op_count), 1);
        issue(1, 3, 5, 2);
        issue(1, 9, 0, 3);
        issue(1, 9, 0, 4);

        // Continuous contention: both requesters refill as soon as served.
        grant_log.delete();
        drive(0, $urandom_range(15), $urandom_range(15), $urandom_range(7));
        drive(1, $urandom_range(15), $urandom_range(15), $urandom_range(7));
        t = 0;
        while (grant_log.size() < 4 && t < 100) begin
            step();
            t++;
            if (!bus.req_valid[0]) drive(0, $urandom_range(15), $urandom_range(15), $urandom_range(7));
            if (!bus.req_valid[1]) drive(1, $urandom_range(15), $urandom_range(15), $urandom_range(7));
        end
        chk("rr_grant_count", grant_log.size(), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) chk("rr_order", grant_log[k], exp_rr[k]);
        bus.req_valid = 2'b00;
        wait_idle();

        // Backpressure with a competing request waiting.
        bus.rsp_ready = 1'b0;
        drive(0, 7, 2, 1);
        t = 0;
        while (!bus.rsp_valid && t < 20) begin step(); t++; end
        if (t >= 20) chk("timeout_rsp", 0, 1);
        drive(1, 5, 5, 2);
        cnt = int'(bus.op_count);
        repeat (3) step();
        chk("bp_op_count", int'(bus.op_count), cnt);
        bus.rsp_ready = 1'b1;
        wait_idle();

        // Reset while the operation is in EXEC.
        drive(0, 12, 3, 1);
        t = 0;
        while (bus.req_valid[0] && t < 20) begin step(); t++; end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_values();
        grant_log.delete();
        drive(0, 1, 2, 1);
        drive(1, 3, 4, 1);
        t = 0;
        while (grant_log.size() < 1 && t < 20) begin step(); t++; end
        chk("post_reset_tie", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        wait_idle();

        do_reset();
        bus.rsp_ready = 1'b1;
        repeat (256) issue(0, $urandom_range(15), $urandom_range(15), $urandom_range(7));
        @(negedge clk);
        chk("op_count_wrap", int'(bus.op_count), 0);

        repeat (800) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (!bus.req_valid[i] && $urandom_range(2) == 0)
                    drive(i, $urandom_range(15), $urandom_range(15), $urandom_range(7));
                else if (bus.req_valid[i] && $urandom_range(9) == 0)
                    bus.req_valid[i] = 1'b0;
            end
            bus.rsp_ready = ($urandom_range(3) != 0);
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b00;
        wait_idle();
        chk("queue_drained", q.size(), 0);

        // Fixed-priority instance: requester 0 wins every tie.
        @(posedge clk);
        #1;
        bus_fp.req_valid = 2'b11;
        cnt = 0;
        rsp_cnt = 0;
        t = 0;
        while (cnt < 4 && t < 60) begin
            @(negedge clk);
            t++;
            if (bus_fp.req_ready != 2'b00) begin
                chk("fp_grant", int'(bus_fp.req_ready), 1);
                cnt++;
            end
            if (bus_fp.rsp_valid && bus_fp.rsp_ready) begin
                chk("fp_rsp_id", int'(bus_fp.rsp_id), 0);
                chk("fp_rsp_out", int'(bus_fp.rsp_out), 9);
                rsp_cnt++;
            end
        end
        chk("fp_grant_count", cnt, 4);
        chk("fp_rsp_count", rsp_cnt, 3);
        @(posedge clk);
        #1;
        bus_fp.req_valid = 2'b00;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
